// File: rtl/fixed_point_subtract_sequencer.sv
// fixed_point_subtract_sequencer: word-serial wide subtract over an N-bit subtractor; FIXED_POINT_SUB_SEQ_SATURATE_EN adds result clamping
module fixed_point_subtract_sequencer #(
  parameter int N = 32,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_signed,
  output logic [N-1:0]       sub_a,
  output logic [N-1:0]       sub_b,
  output logic               sub_carry_in,
  input  logic [N-1:0]       sub_c,
  input  logic               sub_carry_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_c,
  output logic               out_borrow,
  output logic               out_overflow,
  output logic               busy
);
  localparam int W = N * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WORDS-1:0][N-1:0] a_q, b_q, res_q;
  logic [IW-1:0] idx;
  logic carry, signed_q, last, run, done, accept, a_msb, b_msb, c_msb;
  assign last = idx == IW'(WORDS - 1);
  assign run = state == RUN;
  assign done = state == DONE;
  assign accept = in_ready && in_valid;
  assign a_msb = a_q[WORDS-1][N-1];
  assign b_msb = b_q[WORDS-1][N-1];
  assign c_msb = res_q[WORDS-1][N-1];
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state and handshake/subtractor drive
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
    in_ready = state == IDLE && !rst;
    sub_a = run ? a_q[idx] : '0;
    sub_b = run ? b_q[idx] : '0;
    sub_carry_in = run && carry;
  end
  // operand capture and LSB-first word accumulation with carry chaining
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      signed_q <= 1'b0;
      idx <= '0;
      carry <= 1'b1;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
      signed_q <= in_signed;
      idx <= '0;
      carry <= 1'b1;
    end else if (run) begin
      res_q[idx] <= sub_c;
      carry <= sub_carry_out;
      idx <= last ? '0 : idx + IW'(1);
    end
  end
  assign out_valid = done;
  assign busy = state != IDLE;
  assign out_borrow = done && !carry;
  assign out_overflow = done && signed_q && (a_msb != b_msb) && (c_msb != a_msb);
`ifdef FIXED_POINT_SUB_SEQ_SATURATE_EN
  assign out_c = out_overflow ? {a_msb, {(W-1){!a_msb}}} :
                 (out_borrow && !signed_q) ? '0 : res_q;
`else
  assign out_c = res_q;
`endif
endmodule

// File: tb/tb_fixed_point_subtract_sequencer.sv
// tb_fixed_point_subtract_sequencer: directed checks of the wide subtract sequencer with a behavioural word subtractor
module tb_fixed_point_subtract_sequencer;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_signed, sub_carry_in, sub_carry_out;
  logic out_valid, out_ready, out_borrow, out_overflow, busy;
  logic [127:0] in_a, in_b, out_c;
  logic [31:0] sub_a, sub_b, sub_c;
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MAXP = {1'b0, {127{1'b1}}};
  localparam logic [127:0] MINN = {1'b1, 127'b0};

  fixed_point_subtract_sequencer #(.N(32), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .sub_a(sub_a), .sub_b(sub_b), .sub_carry_in(sub_carry_in),
    .sub_c(sub_c), .sub_carry_out(sub_carry_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_borrow(out_borrow), .out_overflow(out_overflow), .busy(busy)
  );

  assign {sub_carry_out, sub_c} = {1'b0, sub_a} + {1'b0, ~sub_b} + {32'b0, sub_carry_in};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] a, input logic [127:0] b, input logic s);
    in_a = a;
    in_b = b;
    in_signed = s;
    in_valid = 1'b1;
    #1;
    chk("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output logic [3:0] cin);
    n = 0;
    cin = 4'b0;
    while (!out_valid && n < 20) begin
      if (n < 4) cin[n] = sub_carry_in;
      tick();
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_dropped", out_valid, 0);
    chk("idle_after_release", busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [127:0] a, input logic [127:0] b, input logic s,
                        input logic [127:0] ec, input logic eb, input logic eo, input logic [3:0] ecin);
    int n;
    logic [3:0] cin;
    start(a, b, s);
    wait_valid(n, cin);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_carry_seq"}, cin, ecin);
    chk({tag, "_c"}, out_c, ec);
    chk({tag, "_borrow"}, out_borrow, eb);
    chk({tag, "_overflow"}, out_overflow, eo);
    release_out();
  endtask

  initial begin
    int n;
    logic [3:0] cin;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_borrow", out_borrow, 0);
    chk("rst_overflow", out_overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sub", {sub_a, sub_b, sub_carry_in}, 0);
    rst = 1'b0;
    tick();
    run_op("one_minus_zero", 128'd1, 128'd0, 1'b0, 128'd1, 1'b0, 1'b0, 4'b1111);
`ifdef FIXED_POINT_SUB_SEQ_SATURATE_EN
    run_op("zero_minus_one_u", 128'd0, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0, 4'b0001);
`else
    run_op("zero_minus_one_u", 128'd0, 128'd1, 1'b0, ONES, 1'b1, 1'b0, 4'b0001);
`endif
    run_op("zero_minus_one_s", 128'd0, 128'd1, 1'b1, ONES, 1'b1, 1'b0, 4'b0001);
    run_op("carry_chain", 128'h1_0000_0000, 128'd1, 1'b0, 128'hFFFF_FFFF, 1'b0, 1'b0, 4'b1101);
`ifdef FIXED_POINT_SUB_SEQ_SATURATE_EN
    run_op("signed_ovf", MAXP, ONES, 1'b1, MAXP, 1'b1, 1'b1, 4'b1111);
`else
    run_op("signed_ovf", MAXP, ONES, 1'b1, MINN, 1'b1, 1'b1, 4'b1111);
`endif
    start(128'd10, 128'd3, 1'b0);
    wait_valid(n, cin);
    chk("bp_latency", n, 4);
    in_a = 128'd100;
    in_b = 128'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_c_hold", out_c, 128'd7);
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_new_accept", busy, 1);
    wait_valid(n, cin);
    chk("bp_new_latency", n, 4);
    chk("bp_new_c", out_c, 128'd99);
    release_out();
    start(128'd40, 128'd2, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sub", {sub_a, sub_b, sub_carry_in}, 0);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("midrst_no_valid", out_valid, 0);
    run_op("after_rst", 128'd5, 128'd3, 1'b0, 128'd2, 1'b0, 1'b0, 4'b1111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
